// File: rtl/conv_encoder_bn_controller.sv
// conv_encoder_bn_controller: per-channel parameter fetch and pixel sequencer
// for the conv encoder's batch-normalization unit (y = (x*p + q) >>> 9).
// Optional build macro BN_RELU_EN fuses a ReLU onto out_data.
module conv_encoder_bn_controller #(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned PIXELS   = 64,
    parameter int unsigned CH_W     = 4,
    parameter int unsigned PIX_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    output logic              busy,
    output logic              frame_done,
    output logic              param_rd_en,
    output logic [CH_W-1:0]   param_addr,
    input  logic [53:0]       param_data,
    input  logic              in_valid,
    input  logic [17:0]       in_data,
    output logic              in_ready,
    output logic              bn_start,
    output logic [17:0]       bn_x,
    output logic [17:0]       bn_p,
    output logic [35:0]       bn_q,
    input  logic [17:0]       bn_pixel,
    output logic              out_valid,
    output logic [17:0]       out_data,
    output logic              out_ch_last,
    output logic              out_last
);

    localparam int unsigned PIX_DW = 18;
    localparam int unsigned P_W    = 18;
    localparam int unsigned Q_W    = 36;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [P_W-1:0]      p_q, p_d;
    logic [Q_W-1:0]      q_q, q_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_en_q, rd_en_d;
    logic [CH_W-1:0]     addr_q, addr_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                out_ch_last_q, out_ch_last_d;
    logic                out_last_q, out_last_d;
    logic [PIX_DW-1:0]   hold_q, hold_d;

    logic                xfer_c;
    logic                pix_last_c;
    logic                ch_last_c;
    logic [PIX_DW-1:0]   result_c;

    assign xfer_c     = in_valid && in_ready_q;
    assign pix_last_c = (pix_q == PIX_LAST);
    assign ch_last_c  = (ch_q == CH_LAST);

`ifdef BN_RELU_EN
    assign result_c = bn_pixel[PIX_DW-1] ? '0 : bn_pixel;
`else
    assign result_c = bn_pixel;
`endif

    // Next-state, counters, parameter latch and registered-output precompute
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        pix_d         = pix_q;
        p_d           = p_q;
        q_d           = q_q;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    ch_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                p_d     = param_data[53:36];
                q_d     = param_data[35:0];
                pix_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (xfer_c) begin
                    pix_d = pix_q + PIX_W'(1);
                    if (pix_last_c) begin
                        if (ch_last_c) begin
                            state_d = S_DRAIN;
                        end else begin
                            ch_d    = ch_q + CH_W'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // busy drops in DONE so it falls in the same cycle frame_done pulses
        busy_d        = (state_d == S_FETCH) || (state_d == S_WAIT) ||
                        (state_d == S_RUN)   || (state_d == S_DRAIN);
        done_d        = (state_d == S_DONE);
        rd_en_d       = (state_d == S_FETCH);
        addr_d        = (state_d == S_FETCH) ? ch_d : '0;
        in_ready_d    = (state_d == S_RUN);
        out_valid_d   = xfer_c;
        out_ch_last_d = xfer_c && pix_last_c;
        out_last_d    = xfer_c && pix_last_c && ch_last_c;
        hold_d        = out_valid_q ? result_c : hold_q;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            ch_q          <= '0;
            pix_q         <= '0;
            p_q           <= '0;
            q_q           <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rd_en_q       <= 1'b0;
            addr_q        <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_ch_last_q <= 1'b0;
            out_last_q    <= 1'b0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            pix_q         <= pix_d;
            p_q           <= p_d;
            q_q           <= q_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rd_en_q       <= rd_en_d;
            addr_q        <= addr_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_ch_last_q <= out_ch_last_d;
            out_last_q    <= out_last_d;
            hold_q        <= hold_d;
        end
    end

    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign param_rd_en = rd_en_q;
    assign param_addr  = addr_q;
    assign in_ready    = in_ready_q;
    assign bn_start    = xfer_c;
    assign bn_x        = in_data;
    assign bn_p        = p_q;
    assign bn_q        = q_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_valid_q ? result_c : hold_q;
    assign out_ch_last = out_ch_last_q;
    assign out_last    = out_last_q;

endmodule

// File: tb/tb_conv_encoder_bn_controller.sv
// Bench for conv_encoder_bn_controller: table vectors, random frames against a
// frame-level reference model, plus reset / stray-start / single-pixel cases.
module tb_conv_encoder_bn_controller;

    localparam int CH = 2;
    localparam int PX = 4;
    localparam int NT = CH * PX;

    typedef struct {
        logic [CH-1:0][17:0] p;
        logic [CH-1:0][35:0] q;
        logic [NT-1:0][17:0] x;
        logic [NT-1:0][17:0] exp;
        int                  mode;
        bit                  glitch;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic        busy, frame_done, param_rd_en;
    logic [0:0]  param_addr;
    logic [53:0] param_data = '0;
    logic        in_valid = 1'b0;
    logic [17:0] in_data = '0;
    logic        in_ready, bn_start;
    logic [17:0] bn_x, bn_p;
    logic [35:0] bn_q;
    logic [17:0] bn_pixel = '0;
    logic        out_valid, out_ch_last, out_last;
    logic [17:0] out_data;

    logic        s_start = 1'b0;
    logic        s_busy, s_done, s_rd;
    logic [0:0]  s_addr;
    logic [53:0] s_pdata = '0;
    logic        s_valid = 1'b0;
    logic [17:0] s_data = '0;
    logic        s_ready, s_bn_start;
    logic [17:0] s_bn_x, s_bn_p;
    logic [35:0] s_bn_q;
    logic [17:0] s_bn_pixel = '0;
    logic        s_out_valid, s_out_ch_last, s_out_last;
    logic [17:0] s_out_data;

    logic [53:0] pmem [CH];

    int n_chk  = 0;
    int n_pass = 0;

    conv_encoder_bn_controller #(.CHANNELS(CH), .PIXELS(PX), .CH_W(1), .PIX_W(2)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .busy(busy),
        .frame_done(frame_done), .param_rd_en(param_rd_en), .param_addr(param_addr),
        .param_data(param_data), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .bn_start(bn_start), .bn_x(bn_x), .bn_p(bn_p),
        .bn_q(bn_q), .bn_pixel(bn_pixel), .out_valid(out_valid),
        .out_data(out_data), .out_ch_last(out_ch_last), .out_last(out_last)
    );

    conv_encoder_bn_controller #(.CHANNELS(1), .PIXELS(1), .CH_W(1), .PIX_W(1)) dut_1x1 (
        .clk(clk), .rst(rst), .frame_start(s_start), .busy(s_busy),
        .frame_done(s_done), .param_rd_en(s_rd), .param_addr(s_addr),
        .param_data(s_pdata), .in_valid(s_valid), .in_data(s_data),
        .in_ready(s_ready), .bn_start(s_bn_start), .bn_x(s_bn_x), .bn_p(s_bn_p),
        .bn_q(s_bn_q), .bn_pixel(s_bn_pixel), .out_valid(s_out_valid),
        .out_data(s_out_data), .out_ch_last(s_out_ch_last), .out_last(s_out_last)
    );

    // y = (x*p + q) >>> 9, truncated to 18 bits
    function automatic logic [17:0] bn_model(input logic [17:0] x, input logic [17:0] p,
                                             input logic [35:0] q);
        longint t;
        t = longint'($signed(x)) * longint'($signed(p)) + longint'($signed(q));
        t = t >>> 9;
        return t[17:0];
    endfunction

    function automatic logic [17:0] relu_exp(input logic [17:0] y);
`ifdef BN_RELU_EN
        return y[17] ? 18'd0 : y;
`else
        return y;
`endif
    endfunction

    // External BN units and parameter memories (junk data when not read)
    always @(posedge clk) begin
        if (bn_start) bn_pixel <= bn_model(bn_x, bn_p, bn_q);
        if (s_bn_start) s_bn_pixel <= bn_model(s_bn_x, s_bn_p, s_bn_q);
        param_data <= param_rd_en ? pmem[param_addr] : 54'({$urandom(), $urandom()});
        s_pdata    <= s_rd ? {18'd512, 36'd1024} : 54'({$urandom(), $urandom()});
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " frame_done"}, frame_done, 0);
        chk({nm, " param_rd_en"}, param_rd_en, 0);
        chk({nm, " param_addr"}, param_addr, 0);
        chk({nm, " in_ready"}, in_ready, 0);
        chk({nm, " bn_start"}, bn_start, 0);
        chk({nm, " bn_x"}, bn_x, 0);
        chk({nm, " bn_p"}, bn_p, 0);
        chk({nm, " bn_q"}, bn_q, 0);
        chk({nm, " out_valid"}, out_valid, 0);
        chk({nm, " out_data"}, out_data, 0);
        chk({nm, " out_ch_last"}, out_ch_last, 0);
        chk({nm, " out_last"}, out_last, 0);
    endtask

    // Drives one complete frame and checks the output stream against v.exp
    task automatic run_frame(input vec_t v, input string nm);
        int k, last_x, done_n, done_c, nready, post;
        bit done_b, vbit;
        int xq[$];
        int oc[$];
        int aq[$];
        logic [17:0] od[$];
        bit ochl[$];
        bit olst[$];
        k = 0; last_x = -100; done_n = 0; done_c = -1; nready = 0; post = 0; done_b = 1'b1;
        for (int c = 0; c < CH; c++) pmem[c] = {v.p[c], v.q[c]};
        for (int cyc = 0; cyc < 300 && post < 4; cyc++) begin
            @(posedge clk); #1;
            frame_start = (cyc == 0) || (v.glitch && ((k > 0 && k < NT) || cyc == last_x + 2));
            case (v.mode)
                0:       vbit = 1'b1;
                1:       vbit = (cyc % 3) == 0;
                default: vbit = 1'($urandom_range(0, 1));
            endcase
            in_valid = (k < NT) && vbit;
            in_data  = in_valid ? v.x[k] : 18'($urandom());
            @(negedge clk);
            if (in_valid && in_ready) begin
                xq.push_back(cyc);
                k++;
                if (k == NT) last_x = cyc;
            end
            if (out_valid) begin
                oc.push_back(cyc); od.push_back(out_data);
                ochl.push_back(out_ch_last); olst.push_back(out_last);
            end
            if (param_rd_en) aq.push_back(int'(param_addr));
            if (busy && !in_ready) nready++;
            if (frame_done) begin done_n++; done_c = cyc; done_b = busy; end
            if (done_n > 0) post++;
        end
        @(posedge clk); #1;
        frame_start = 1'b0; in_valid = 1'b0;
        chk({nm, " transfers"}, k, NT);
        chk({nm, " outputs"}, oc.size(), NT);
        for (int i = 0; i < oc.size() && i < NT; i++) begin
            chk($sformatf("%s out%0d data", nm, i), longint'($signed(od[i])),
                longint'($signed(relu_exp(v.exp[i]))));
            chk($sformatf("%s out%0d ch_last", nm, i), ochl[i], (i % PX) == PX - 1);
            chk($sformatf("%s out%0d last", nm, i), olst[i], i == NT - 1);
            if (i < xq.size()) chk($sformatf("%s out%0d latency", nm, i), oc[i] - xq[i], 1);
        end
        chk({nm, " frame_done count"}, done_n, 1);
        chk({nm, " frame_done cycle"}, done_c, last_x + 2);
        chk({nm, " busy at frame_done"}, done_b, 0);
        chk({nm, " param reads"}, aq.size(), CH);
        for (int i = 0; i < aq.size() && i < CH; i++)
            chk($sformatf("%s param_addr%0d", nm, i), aq[i], i);
        chk({nm, " in_ready low cycles"}, nready, 2 * CH + 1);
        if (v.mode == 0 && xq.size() > PX)
            chk({nm, " channel gap"}, xq[PX] - xq[PX-1], 3);
        chk({nm, " busy after"}, busy, 0);
    endtask

    task automatic reset_mid_run();
        int k, nd, nb;
        k = 0; nd = 0; nb = 0;
        for (int c = 0; c < CH; c++) pmem[c] = {18'd512, 36'd0};
        for (int cyc = 0; cyc < 30 && k < 3; cyc++) begin
            @(posedge clk); #1;
            frame_start = (cyc == 0);
            in_valid = 1'b1; in_data = 18'(k + 10);
            @(negedge clk);
            if (in_valid && in_ready) k++;
        end
        chk("rst_mid pixels before reset", k, 3);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; frame_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_zero("rst_mid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nd += int'(frame_done);
            nb += int'(busy);
        end
        chk("rst_mid no frame_done", nd, 0);
        chk("rst_mid stays idle", nb, 0);
    endtask

    task automatic run_single();
        int oc, n_out, dc, nd, na, addr;
        logic [17:0] od;
        bit chl, lst;
        oc = -1; n_out = 0; dc = -1; nd = 0; na = 0; addr = -1; od = '0; chl = 0; lst = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(posedge clk); #1;
            s_start = (cyc == 0); s_valid = 1'b1; s_data = 18'd77;
            @(negedge clk);
            if (s_out_valid) begin
                n_out++; oc = cyc; od = s_out_data; chl = s_out_ch_last; lst = s_out_last;
            end
            if (s_done) begin nd++; dc = cyc; end
            if (s_rd) begin na++; addr = int'(s_addr); end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("1x1 outputs", n_out, 1);
        chk("1x1 data", longint'($signed(od)), 79);
        chk("1x1 ch_last", chl, 1);
        chk("1x1 last", lst, 1);
        chk("1x1 frame_done count", nd, 1);
        chk("1x1 frame_done cycle", dc - oc, 1);
        chk("1x1 param reads", na, 1);
        chk("1x1 param_addr", addr, 0);
    endtask

    vec_t tbl [4];
    vec_t rv;

    initial begin
        int x_id[8] = '{100, -7, 3, 0, 100, -7, 3, 0};
        int x_sg[8] = '{-50, 50, -1, 0, -50, 50, -1, 0};
        int e_sg[8] = '{-50, 50, -1, 0, -51, 49, -2, -1};

        tbl[0].p[0] = 18'd512;  tbl[0].p[1] = 18'd512;
        tbl[0].q[0] = 36'd0;    tbl[0].q[1] = 36'd0;
        tbl[1].p[0] = 18'd1024; tbl[1].p[1] = 18'd256;
        tbl[1].q[0] = 36'd5120; tbl[1].q[1] = 36'(-2560);
        tbl[2].p[0] = 18'd512;  tbl[2].p[1] = 18'd512;
        tbl[2].q[0] = 36'd0;    tbl[2].q[1] = 36'd0;
        tbl[3].p[0] = 18'd512;  tbl[3].p[1] = 18'd512;
        tbl[3].q[0] = 36'd0;    tbl[3].q[1] = 36'(-1);
        for (int i = 0; i < NT; i++) begin
            tbl[0].x[i] = 18'(x_id[i]);  tbl[0].exp[i] = 18'(x_id[i]);
            tbl[1].x[i] = 18'd100;       tbl[1].exp[i] = (i < PX) ? 18'd210 : 18'd45;
            tbl[2].x[i] = 18'(i + 1);    tbl[2].exp[i] = 18'(i + 1);
            tbl[3].x[i] = 18'(x_sg[i]);  tbl[3].exp[i] = 18'(e_sg[i]);
        end
        tbl[0].mode = 0; tbl[0].glitch = 1'b0;
        tbl[1].mode = 0; tbl[1].glitch = 1'b1;
        tbl[2].mode = 1; tbl[2].glitch = 1'b0;
        tbl[3].mode = 0; tbl[3].glitch = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        for (int t = 0; t < 4; t++) run_frame(tbl[t], $sformatf("vec%0d", t));

        reset_mid_run();
        run_frame(tbl[0], "after_reset");

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < CH; c++) begin
                rv.p[c] = 18'($urandom());
                rv.q[c] = 36'({$urandom(), $urandom()});
            end
            for (int i = 0; i < NT; i++) begin
                rv.x[i]   = 18'($urandom());
                rv.exp[i] = bn_model(rv.x[i], rv.p[i / PX], rv.q[i / PX]);
            end
            rv.mode   = 2;
            rv.glitch = 1'($urandom_range(0, 1));
            run_frame(rv, $sformatf("rand%0d", r));
        end

        run_single();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
